// File: rtl/btn_press_capture.sv
// Debounced single-cycle press capture for four push-buttons (IDLE/ARM/HELD FSM).
// Optional 2-flop input synchronizer enabled by defining SIMON_BTN_SYNC_EN.
module btn_press_capture #(
    parameter int DEB_TICKS = 4,
    parameter int CW        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [3:0] btn,
    output logic       btn_valid,
    output logic [1:0] btn_val,
    output logic       multi_err,
    output logic       busy,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2
    } state_t;

    localparam logic [CW-1:0] L_TICKS = CW'(DEB_TICKS);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic          r_valid;
    logic [1:0]    r_val;
    logic          r_merr;
    logic          r_busy;

    logic [3:0]    w_btn_s;
    logic [CW-1:0] w_cnt_inc;
    logic          w_onehot;
    logic [1:0]    w_idx;

`ifdef SIMON_BTN_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;
`else
    assign w_btn_s = btn;
`endif

    function automatic logic [1:0] f_index(input logic [3:0] v);
        f_index = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) f_index = 2'(i);
        end
    endfunction

    // Saturating increment: the counter parks at DEB_TICKS instead of wrapping.
    assign w_cnt_inc = (r_cnt >= L_TICKS) ? L_TICKS : r_cnt + CW'(1);
    assign w_onehot  = (w_btn_s != 4'd0) && ((w_btn_s & (w_btn_s - 4'd1)) == 4'd0);
    assign w_idx     = f_index(w_btn_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HELD;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_val   <= 2'd0;
            r_merr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_merr  <= 1'b0;
            if (sample_en) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_btn_s != 4'd0) begin
                            r_code <= w_btn_s;
                            if (DEB_TICKS == 1) begin
                                r_valid <= w_onehot;
                                r_merr  <= !w_onehot;
                                if (w_onehot) r_val <= w_idx;
                                r_state <= HELD;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= ARM;
                                r_busy  <= 1'b1;
                                r_cnt   <= CW'(1);
                            end
                        end
                    end
                    ARM: begin
                        if (w_btn_s == r_code) begin
                            if (w_cnt_inc == L_TICKS) begin
                                r_valid <= w_onehot;
                                r_merr  <= !w_onehot;
                                if (w_onehot) r_val <= w_idx;
                                r_state <= HELD;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else if (w_btn_s == 4'd0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_code <= w_btn_s;
                            r_cnt  <= CW'(1);
                        end
                    end
                    HELD: begin
                        if (w_btn_s == 4'd0) begin
                            if (w_cnt_inc == L_TICKS) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= HELD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_valid = r_valid;
    assign btn_val   = r_val;
    assign multi_err = r_merr;
    assign busy      = r_busy;
    assign state_o   = r_state;

endmodule

// File: tb/tb_btn_press_capture.sv
// Directed scenarios plus random stimulus for btn_press_capture, checked cycle by cycle
// against a sample-history reference model.
module tb_btn_press_capture;

    localparam int DEB = 4;
`ifdef SIMON_BTN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = DEB + SYNC_LAT;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       sample_en = 1'b1;
    logic [3:0] btn       = 4'd0;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic       multi_err;
    logic       busy;
    logic [1:0] state_o;

    btn_press_capture #(.DEB_TICKS(DEB), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .btn       (btn),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .multi_err (multi_err),
        .busy      (busy),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_seen = 0;
    int n_merr_seen  = 0;

    // Reference model: "ready" means a release has been accepted; the history holds the
    // samples taken since the last mode change, trimmed to the debounce window.
    bit         m_ready = 1'b0;
    logic [3:0] m_hist[$];
    logic [1:0] m_val   = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_merr  = 1'b0;
    logic [3:0] m_d1    = 4'd0;
    logic [3:0] m_d2    = 4'd0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (!m_ready) return 2'd2;
        if (m_hist.size() > 0 && m_hist[$] != 4'd0) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [3:0] b);
        logic [3:0] s;
        bit all_eq;
        bit all_zero;
        s    = (SYNC_LAT > 0) ? m_d2 : b;
        m_d2 = m_d1;
        m_d1 = b;
        m_valid = 1'b0;
        m_merr  = 1'b0;
        if (rst) begin
            m_ready = 1'b0;
            m_hist.delete();
            m_val = 2'd0;
            m_d1  = 4'd0;
            m_d2  = 4'd0;
            return;
        end
        if (!en) return;
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            all_eq   = 1'b1;
            all_zero = 1'b1;
            foreach (m_hist[i]) begin
                if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
                if (m_hist[i] != 4'd0) all_zero = 1'b0;
            end
            if (m_ready && all_eq && !all_zero) begin
                if ($countones(m_hist[0]) == 1) begin
                    m_valid = 1'b1;
                    for (int i = 0; i < 4; i++) if (m_hist[0][i]) m_val = 2'(i);
                end else begin
                    m_merr = 1'b1;
                end
                m_ready = 1'b0;
                m_hist.delete();
            end else if (!m_ready && all_zero) begin
                m_ready = 1'b1;
                m_hist.delete();
            end
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [3:0] b);
        @(negedge clk);
        reset     = rst;
        sample_en = en;
        btn       = b;
        @(posedge clk);
        model_step(rst, en, b);
        #1;
        if (btn_valid === 1'b1) n_valid_seen++;
        if (multi_err === 1'b1) n_merr_seen++;
        check("btn_valid", {3'd0, btn_valid}, {3'd0, m_valid});
        check("multi_err", {3'd0, multi_err}, {3'd0, m_merr});
        check("btn_val",   {2'd0, btn_val},   {2'd0, m_val});
        check("state_o",   {2'd0, state_o},   {2'd0, exp_state()});
        check("busy",      {3'd0, busy},      {3'd0, (exp_state() != 2'd0)});
    endtask

    task automatic run(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, b);
    endtask

    initial begin
        int hold;
        int sel;
        logic [3:0] pat;

        // Scenario 1: reset with idle buttons, then a clean press of button 2.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd0);
        check("reset_state", {2'd0, state_o}, 4'd2);
        check("reset_busy", {3'd0, busy}, 4'd1);
        run(DEB, 4'd0);
        check("idle_after_reset", {2'd0, state_o}, 4'd0);
        n_valid_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 4'b0100);
            if (i == LAT) check("s1_latency", {3'd0, btn_valid}, 4'd1);
        end
        check("s1_pulses", 4'(n_valid_seen), 4'd1);
        check("s1_val", {2'd0, btn_val}, 4'd2);
        check("s1_held", {2'd0, state_o}, 4'd2);
        run(LAT, 4'd0);

        // Scenario 2: button held through reset is never reported.
        n_valid_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0001);
        run(5, 4'b0001);
        run(LAT, 4'd0);
        check("s2_pulses", 4'(n_valid_seen), 4'd0);
        check("s2_idle", {2'd0, state_o}, 4'd0);

        // Scenario 3: bounce rejected, single event on the second run.
        n_valid_seen = 0;
        run(3, 4'b0010);
        run(1, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 4'b0010);
            if (i == LAT) check("s3_latency", {3'd0, btn_valid}, 4'd1);
        end
        check("s3_pulses", 4'(n_valid_seen), 4'd1);
        check("s3_val", {2'd0, btn_val}, 4'd1);
        run(LAT + 1, 4'd0);

        // Scenario 4: two buttons together give one multi_err and no press.
        n_valid_seen = 0;
        n_merr_seen  = 0;
        run(6 + SYNC_LAT, 4'b1001);
        check("s4_merr", 4'(n_merr_seen), 4'd1);
        check("s4_valid", 4'(n_valid_seen), 4'd0);
        check("s4_val_kept", {2'd0, btn_val}, 4'd1);
        run(LAT + 1, 4'd0);

        // Scenario 5: extra button while held is ignored; re-press after release counts.
        n_valid_seen = 0;
        run(6, 4'b1000);
        check("s5_first_val", {2'd0, btn_val}, 4'd3);
        run(5, 4'b1001);
        check("s5_held_pulses", 4'(n_valid_seen), 4'd1);
        run(6, 4'd0);
        run(6 + SYNC_LAT, 4'b0001);
        check("s5_pulses", 4'(n_valid_seen), 4'd2);
        check("s5_second_val", {2'd0, btn_val}, 4'd0);
        run(LAT + 1, 4'd0);

        // Scenario 6: reset in the middle of ARM drops the pending press.
        n_valid_seen = 0;
        run(2 + SYNC_LAT, 4'b0100);
        check("s6_arm", {2'd0, state_o}, 4'd1);
        step(1'b1, 1'b1, 4'b0100);
        check("s6_reset_held", {2'd0, state_o}, 4'd2);
        run(8, 4'b0100);
        check("s6_pulses", 4'(n_valid_seen), 4'd0);
        check("s6_still_held", {2'd0, state_o}, 4'd2);
        run(LAT + 1, 4'd0);

        // Random phase: patterns held for random durations, gaps in sample_en, rare resets.
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      pat = 4'd0;
            else if (sel < 8) pat = 4'(1 << $urandom_range(0, 3));
            else              pat = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++)
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), pat);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
